// File: rtl/brick_collision_scanner.sv
// Scans a brick table in RAM for the first live brick overlapping the ball and clears it.
// Optional score counter enabled by defining BRICK_SCORE_EN.
module brick_collision_scanner #(
  parameter int unsigned NUM_BRICKS = 40,
  parameter int unsigned BRICK_W    = 16,
  parameter int unsigned BRICK_H    = 4,
  parameter int unsigned BALL_SIZE  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [7:0]  ball_x,
  input  logic [6:0]  ball_y,
  output logic [7:0]  ram_address,
  input  logic [17:0] ram_q,
  output logic [17:0] ram_data,
  output logic        ram_wren,
  output logic        busy,
  output logic        done,
  output logic        hit,
  output logic [7:0]  hit_index,
  output logic [7:0]  hit_x,
  output logic [6:0]  hit_y
`ifdef BRICK_SCORE_EN
  ,
  output logic [7:0]  score
`endif
);

  localparam int unsigned AW = 8;
  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned CW = 9;
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_BRICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CHECK = 3'd2,
    S_CLEAR = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   bx_q;
  logic [YW-1:0]   by_q;
  logic [AW-1:0]   index_q;

  // Overlap test, widened so edge sums near 255/127 never wrap
  logic          alive;
  logic          hit_c;
  logic [CW-1:0] ball_x_lo, ball_x_hi, ball_y_lo, ball_y_hi;
  logic [CW-1:0] brk_x_lo, brk_x_hi, brk_y_lo, brk_y_hi;

  always_comb begin
    alive     = |ram_q[17:15];
    ball_x_lo = CW'(bx_q);
    ball_x_hi = CW'(bx_q) + CW'(BALL_SIZE - 1);
    ball_y_lo = CW'(by_q);
    ball_y_hi = CW'(by_q) + CW'(BALL_SIZE - 1);
    brk_x_lo  = CW'(ram_q[7:0]);
    brk_x_hi  = CW'(ram_q[7:0]) + CW'(BRICK_W - 1);
    brk_y_lo  = CW'(ram_q[14:8]);
    brk_y_hi  = CW'(ram_q[14:8]) + CW'(BRICK_H - 1);
    hit_c     = alive &&
                (ball_x_hi >= brk_x_lo) && (ball_x_lo <= brk_x_hi) &&
                (ball_y_hi >= brk_y_lo) && (ball_y_lo <= brk_y_hi);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_READ;
      S_READ:  state_d = S_CHECK;
      S_CHECK: begin
        if (hit_c)                   state_d = S_CLEAR;
        else if (index_q == LAST_IDX) state_d = S_DONE;
        else                          state_d = S_READ;
      end
      S_CLEAR: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Decoded outputs; the write strobe is also gated by reset so a reset edge never writes
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    ram_wren    = 1'b0;
    ram_address = '0;
    ram_data    = '0;
    case (state_q)
      S_READ, S_CHECK: begin
        busy        = 1'b1;
        ram_address = index_q;
      end
      S_CLEAR: begin
        busy        = 1'b1;
        ram_wren    = resetn;
        ram_address = hit_index;
        ram_data    = {3'b000, hit_y, hit_x};
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Scan datapath: captured ball, walking index and held result
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bx_q      <= '0;
      by_q      <= '0;
      index_q   <= '0;
      hit       <= 1'b0;
      hit_index <= '0;
      hit_x     <= '0;
      hit_y     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            bx_q    <= ball_x;
            by_q    <= ball_y;
            index_q <= '0;
            hit     <= 1'b0;
          end
        end
        S_CHECK: begin
          if (hit_c) begin
            hit       <= 1'b1;
            hit_index <= index_q;
            hit_x     <= ram_q[7:0];
            hit_y     <= ram_q[14:8];
          end else if (index_q != LAST_IDX) begin
            index_q <= index_q + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BRICK_SCORE_EN
  // Saturating count of cleared bricks
  always_ff @(posedge clk) begin
    if (!resetn)                                 score <= '0;
    else if (state_q == S_CLEAR && score != 8'hFF) score <= score + 8'd1;
  end
`endif

endmodule
